phi_edge_driver: RTL

//  Producer end of the PHI-node incoming-value interface. Sits at the terminator (br) of a

---
 rtl/phi_edge_if.sv | 29 ++
 rtl/phi_edge_driver.sv | 63 ++++++
 2 files changed

// File: rtl/phi_edge_if.sv
// phi_edge_if: predecessor-side PHI edge bundle (fire/cond/value in, tagged edges and status out)
interface phi_edge_if #(
    parameter int W  = 32,
    parameter int CW = 16
);
    logic          enable;
    logic          cond;
    logic [W-1:0]  value;
    logic          ack_true;
    logic          ack_false;
    logic [W:0]    edge_true;
    logic [W:0]    edge_false;
    logic          start_true;
    logic          start_false;
    logic          busy;
    logic          overrun;
    logic [CW-1:0] cnt_true;
    logic [CW-1:0] cnt_false;

    modport master (
        input  enable, cond, value, ack_true, ack_false,
        output edge_true, edge_false, start_true, start_false, busy, overrun, cnt_true, cnt_false
    );

    modport slave (
        output enable, cond, value, ack_true, ack_false,
        input  edge_true, edge_false, start_true, start_false, busy, overrun, cnt_true, cnt_false
    );
endinterface

// File: rtl/phi_edge_driver.sv
// phi_edge_driver: drives a tagged {taken,data} value onto the branch-selected PHI edge until acked
module phi_edge_driver #(
    parameter int ParamBitWidth   = 32,
    parameter bit ParamUncond     = 1'b0,
    parameter int ParamCountWidth = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    phi_edge_if.master     bus
);
    typedef enum logic {IDLE, HOLD} state_t;
    localparam logic [ParamCountWidth-1:0] one_cnt = ParamCountWidth'(1);

    state_t                     state_q, state_d;
    logic                       sel_q, sel_d;
    logic [ParamBitWidth-1:0]   data_q, data_d;
    logic                       start_q, overrun_q, overrun_d;
    logic [ParamCountWidth-1:0] cnt_t_q, cnt_t_d, cnt_f_q, cnt_f_d;
    logic                       hold, ack_sel, load, new_sel;

    always_comb begin
        hold      = state_q == HOLD;
        ack_sel   = sel_q ? bus.ack_true : bus.ack_false;
        new_sel   = ParamUncond ? 1'b1 : bus.cond;
        load      = bus.enable && (!hold || ack_sel);
        state_d   = load ? HOLD : (hold && ack_sel) ? IDLE : state_q;
        sel_d     = load ? new_sel : sel_q;
        data_d    = load ? bus.value : data_q;
        overrun_d = overrun_q || (hold && bus.enable && !ack_sel);
        cnt_t_d   = (load && new_sel && !(&cnt_t_q)) ? cnt_t_q + one_cnt : cnt_t_q;
        cnt_f_d   = (load && !new_sel && !(&cnt_f_q)) ? cnt_f_q + one_cnt : cnt_f_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            data_q    <= '0;
            start_q   <= 1'b0;
            overrun_q <= 1'b0;
            cnt_t_q   <= '0;
            cnt_f_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            start_q   <= load;
            overrun_q <= overrun_d;
            cnt_t_q   <= cnt_t_d;
            cnt_f_q   <= cnt_f_d;
        end
    end

    // Outputs decode registered state only; async reset clears them at once.
    assign bus.edge_true   = (hold && sel_q) ? {1'b1, data_q} : '0;
    assign bus.edge_false  = (hold && !sel_q && !ParamUncond) ? {1'b1, data_q} : '0;
    assign bus.start_true  = start_q && sel_q;
    assign bus.start_false = start_q && !sel_q && !ParamUncond;
    assign bus.busy        = hold;
    assign bus.overrun     = overrun_q;
    assign bus.cnt_true    = cnt_t_q;
    assign bus.cnt_false   = ParamUncond ? '0 : cnt_f_q;
endmodule
